jk_bank_seq: RTL and testbench



---
 rtl/jk_bank_seq.sv | 115 +++++++++++
 tb/tb_jk_bank_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/jk_bank_seq.sv
// Command sequencer driving the j/k inputs of a WIDTH-bit JK flip-flop bank (load/toggle/count).
// Optional build macro COUNT_SAT_EN: counts saturate at all-ones/all-zeros and finish early.
//
// state  | meaning
// IDLE   | ready for a command, bank holds (j=k=0)
// RUN    | driving j/k from latched op and live q_fb, one bank update per edge
// DONE   | one-cycle completion pulse, bank holds
module jk_bank_seq #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_TOGGLE = 2'b01;
    localparam logic [1:0] OP_UP     = 2'b10;
    localparam logic [1:0] OP_DOWN   = 2'b11;

    state_t            state, state_nxt;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  data_q;
    logic [LEN_W-1:0]  remaining;
    logic [WIDTH-1:0]  up_t, down_t;
    logic [WIDTH-1:0]  lo_mask;
    logic              sat_hit;
    logic              accept;

    assign accept    = (state == S_IDLE) && cmd_valid;
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= OP_LOAD;
            data_q    <= '0;
            remaining <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q      <= cmd_op;
                data_q    <= cmd_data;
                remaining <= cmd_len;
            end else if (state == S_RUN && remaining != '0) begin
                remaining <= remaining - 1'b1;
            end
        end
    end

    // Bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
    always_comb begin
        up_t    = '0;
        down_t  = '0;
        lo_mask = '0;
        up_t[0]   = 1'b1;
        down_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            lo_mask   = WIDTH'((1 << i) - 1);
            up_t[i]   = ((q_fb | ~lo_mask) == '1);
            down_t[i] = ((q_fb & lo_mask) == '0);
        end
    end

    always_comb begin
        sat_hit = 1'b0;
`ifdef COUNT_SAT_EN
        sat_hit = ((op_q == OP_UP) && (q_fb == '1)) || ((op_q == OP_DOWN) && (q_fb == '0));
`endif
    end

    always_comb begin
        state_nxt = state;
        j         = '0;
        k         = '0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op != OP_LOAD && cmd_len == '0) state_nxt = S_DONE;
                    else                                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (sat_hit) begin
                    state_nxt = S_DONE;
                end else begin
                    case (op_q)
                        OP_LOAD:   begin j = data_q; k = ~data_q; end
                        OP_TOGGLE: begin j = data_q; k = data_q;  end
                        OP_UP:     begin j = up_t;   k = up_t;    end
                        default:   begin j = down_t; k = down_t;  end
                    endcase
                    if (op_q == OP_LOAD || remaining == LEN_W'(1)) state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_jk_bank_seq.sv
// Directed bench for jk_bank_seq with a behavioural JK bank on q_fb; honours COUNT_SAT_EN.
module tb_jk_bank_seq;

    localparam logic [1:0] LOAD = 2'b00, TOGGLE = 2'b01, UP = 2'b10, DOWN = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid, cmd_ready, busy, done;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data, j, k;
    logic [7:0] cmd_len;
    logic [3:0] q = 4'b0000;
    int         passed = 0;
    int         total = 0;
    int         lat;

    always #5 clk = ~clk;

    // JK bank: no reset, so it keeps its value through a sequencer reset.
    always @(posedge clk) q <= (j & ~q) | (~k & q);

    jk_bank_seq #(.WIDTH(4), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len), .q_fb(q),
        .j(j), .k(k), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Returns at the negedge in the cycle right after the accepting edge; scrambles fields afterwards.
    task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [7:0] len);
        @(negedge clk);
        cmd_op = op; cmd_data = data; cmd_len = len; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_data = 4'hF; cmd_len = 8'hFF;
    endtask

    task automatic wait_done(output int l);
        l = 1;
        while (done !== 1'b1 && l < 40) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] data,
                           input logic [7:0] len, input int exp_lat, input logic [3:0] exp_q);
        int l;
        issue(op, data, len);
        wait_done(l);
        chk_i({tag, "_latency"}, l, exp_lat);
        chk({tag, "_q"}, q, exp_q);
        @(negedge clk);
        chk1({tag, "_ready_after"}, cmd_ready, 1'b1);
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = LOAD; cmd_data = '0; cmd_len = '0;

        #2 rst_n = 1'b0;
        #1;
        chk1("rst_ready", cmd_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk("rst_j", j, 4'b0000);
        chk("rst_k", k, 4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // LOAD 1010 with len=0: load ignores the length
        issue(LOAD, 4'b1010, 8'd0);
        chk("load_j", j, 4'b1010);
        chk("load_k", k, 4'b0101);
        chk1("load_busy", busy, 1'b1);
        chk1("load_ready_low", cmd_ready, 1'b0);
        @(negedge clk);
        chk1("load_done", done, 1'b1);
        chk("load_q", q, 4'b1010);
        chk("load_done_j", j, 4'b0000);
        @(negedge clk);
        chk1("load_done_drop", done, 1'b0);
        chk1("load_ready", cmd_ready, 1'b1);

        // COUNT_UP len=5 from 1010, step by step
        issue(UP, 4'b0000, 8'd5);
        chk("up_j_cycle1", j, 4'b0001);
        chk1("up_done_cycle1", done, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("up_step_q", q, 4'(4'b1010 + i));
            chk1("up_step_done", done, (i == 5));
        end
        @(negedge clk);

        run_cmd("ld1110", LOAD, 4'b1110, 8'd3, 2, 4'b1110);
`ifdef COUNT_SAT_EN
        run_cmd("up_sat", UP, 4'b0000, 8'd3, 3, 4'b1111);
`else
        run_cmd("up_wrap", UP, 4'b0000, 8'd3, 4, 4'b0001);
`endif

        run_cmd("ld0001", LOAD, 4'b0001, 8'd0, 2, 4'b0001);
`ifdef COUNT_SAT_EN
        run_cmd("down_sat", DOWN, 4'b0000, 8'd2, 3, 4'b0000);
        run_cmd("tog2", TOGGLE, 4'b0011, 8'd2, 3, 4'b0000);
        run_cmd("tog0", TOGGLE, 4'b0011, 8'd0, 1, 4'b0000);
`else
        run_cmd("down_wrap", DOWN, 4'b0000, 8'd2, 3, 4'b1111);
        run_cmd("tog2", TOGGLE, 4'b0011, 8'd2, 3, 4'b1111);
        run_cmd("tog0", TOGGLE, 4'b0011, 8'd0, 1, 4'b1111);
`endif
        run_cmd("tog1", TOGGLE, 4'b0110, 8'd1, 2, 4'b0110 ^ q);

        // Reset in the middle of COUNT_UP len=10
        run_cmd("ld0000", LOAD, 4'b0000, 8'd7, 2, 4'b0000);
        issue(UP, 4'b0000, 8'd10);
        repeat (3) @(negedge clk);
        chk("mid_q_before", q, 4'b0011);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_j", j, 4'b0000);
        chk("mid_rst_k", k, 4'b0000);
        chk1("mid_rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_q_hold", q, 4'b0011);
        chk1("mid_rst_no_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd("ld_after_rst", LOAD, 4'b0101, 8'd0, 2, 4'b0101);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
